io_uart_tx: RTL and testbench



---
 rtl/io_uart_tx_pkg.sv | 31 +++
 rtl/io_sync_fifo.sv | 66 ++++++
 rtl/io_uart_tx.sv | 173 +++++++++++++++++
 tb/tb_io_uart_tx.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_uart_tx_pkg.sv
// Shared constants, store-decode payload and TX FSM encoding for the IO UART transmitter.
package io_uart_tx_pkg;

  localparam int unsigned IO_DEF_BAUD_DIV = 434;
  localparam logic [9:0]  IO_ADR_TXDATA   = 10'h000;
  localparam logic [9:0]  IO_ADR_BAUD     = 10'h001;
  localparam logic [9:0]  IO_ADR_CTRL     = 10'h002;

  localparam int unsigned BAUD_W   = 16;
  localparam logic [BAUD_W-1:0] BAUD_MIN = 16'd2;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // One-hot view of which register an IO store hits this cycle
  typedef struct packed {
    logic txdata;
    logic baud;
    logic ctrl;
  } io_dec_t;

  // A divider below 2 cannot form a bit period, so clamp it
  function automatic logic [BAUD_W-1:0] clamp_baud(input logic [BAUD_W-1:0] div);
    return (div < BAUD_MIN) ? BAUD_MIN : div;
  endfunction

endpackage

// File: rtl/io_sync_fifo.sv
// Synchronous first-word fall-through FIFO with flush and registered fill level.
module io_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [$clog2(DEPTH):0]   level_nxt_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q;
  logic             push_ok_c, pop_ok_c;

  assign empty_c   = (wr_ptr_q == rd_ptr_q);
  assign full_c    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_c   = mem_q[rd_ptr_q[AW-1:0]];
  assign pop_ok_c  = pop_i && !empty_c;
  // A pop in the same cycle frees the slot the push needs
  assign push_ok_c = push_i && (!full_c || pop_ok_c);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok_c) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (pop_ok_c)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  assign level_nxt_c = wr_ptr_d - rd_ptr_d;
  assign level_o     = level_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_nxt_c;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_c && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the CPU IO store port: decode, baud register,
// sticky overflow flag, TX FIFO and the serialising FSM.
module io_uart_tx
  import io_uart_tx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned DEF_BAUD_DIV = IO_DEF_BAUD_DIV,
  parameter logic [9:0]  ADR_TXDATA   = IO_ADR_TXDATA,
  parameter logic [9:0]  ADR_BAUD     = IO_ADR_BAUD,
  parameter logic [9:0]  ADR_CTRL     = IO_ADR_CTRL
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [11:2]                   st_adr_io,
  input  logic [31:0]                   st_data_io,
  input  logic [3:0]                    st_we_io,
  output logic                          uart_tx,
  output logic                          tx_busy,
  output logic                          tx_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  io_dec_t           dec_c;
  logic              flush_c, ovf_clr_c, ovf_set_c, pop_c;
  logic              fifo_full_c, fifo_empty_c;
  logic [7:0]        fifo_rdata_c;
  logic [LVL_W-1:0]  level_nxt_c;
  logic              unused_c;

  tx_state_e         state_q, state_d;
  logic [BAUD_W-1:0] baud_div_q;
  logic [BAUD_W-1:0] shadow_q, shadow_d;
  logic [BAUD_W-1:0] timer_q, timer_d;
  logic [7:0]        shift_q, shift_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic              tx_q, tx_d;
  logic              busy_q, ovf_q;

  always_comb begin
    dec_c.txdata = st_we_io[0] && (st_adr_io == ADR_TXDATA);
    dec_c.baud   = (&st_we_io[1:0]) && (st_adr_io == ADR_BAUD);
    dec_c.ctrl   = st_we_io[0] && (st_adr_io == ADR_CTRL);
  end

  assign flush_c   = dec_c.ctrl && st_data_io[1];
  assign ovf_clr_c = dec_c.ctrl && st_data_io[0];
  assign ovf_set_c = dec_c.txdata && fifo_full_c && !pop_c;
  assign unused_c  = ^{st_data_io[31:16], st_we_io[3:2]};

  io_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (dec_c.txdata),
    .pop_i       (pop_c),
    .flush_i     (flush_c),
    .wdata_i     (st_data_io[7:0]),
    .rdata_c     (fifo_rdata_c),
    .full_c      (fifo_full_c),
    .empty_c     (fifo_empty_c),
    .level_o     (fifo_level),
    .level_nxt_c (level_nxt_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= TX_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TX_IDLE:  if (!fifo_empty_c) state_d = TX_START;
      TX_START: if (timer_q == '0) state_d = TX_DATA;
      TX_DATA:  if (timer_q == '0 && bit_cnt_q == 3'd7) state_d = TX_STOP;
      TX_STOP:  if (timer_q == '0) state_d = fifo_empty_c ? TX_IDLE : TX_START;
      default:  state_d = TX_IDLE;
    endcase
  end

  // Datapath: frame load, bit timer and shifter; a frame load latches the divider
  always_comb begin
    pop_c     = 1'b0;
    shadow_d  = shadow_q;
    timer_d   = timer_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    case (state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty_c) begin
          pop_c    = 1'b1;
          shift_d  = fifo_rdata_c;
          shadow_d = baud_div_q;
          timer_d  = baud_div_q - 16'd1;
          tx_d     = 1'b0;
        end
      end
      TX_START: begin
        if (timer_q == '0) begin
          timer_d   = shadow_q - 16'd1;
          bit_cnt_d = 3'd0;
          tx_d      = shift_q[0];
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      TX_DATA: begin
        if (timer_q == '0) begin
          timer_d = shadow_q - 16'd1;
          if (bit_cnt_q == 3'd7) begin
            tx_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      TX_STOP: begin
        if (timer_q == '0) begin
          tx_d = 1'b1;
          if (!fifo_empty_c) begin
            pop_c    = 1'b1;
            shift_d  = fifo_rdata_c;
            shadow_d = baud_div_q;
            timer_d  = baud_div_q - 16'd1;
            tx_d     = 1'b0;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_div_q <= 16'(DEF_BAUD_DIV);
      shadow_q   <= 16'(DEF_BAUD_DIV);
      timer_q    <= '0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      if (dec_c.baud) baud_div_q <= clamp_baud(st_data_io[15:0]);
      shadow_q  <= shadow_d;
      timer_q   <= timer_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      busy_q    <= (state_d != TX_IDLE) || (level_nxt_c != '0);
      // Set wins over a same-cycle clear
      if (ovf_set_c)      ovf_q <= 1'b1;
      else if (ovf_clr_c) ovf_q <= 1'b0;
    end
  end

  assign uart_tx     = tx_q;
  assign tx_busy     = busy_q;
  assign tx_overflow = ovf_q;

endmodule

// File: tb/tb_io_uart_tx.sv
// Bench for io_uart_tx: directed scenarios plus randomized traffic; the serial line is
// compared cycle-by-cycle against an ideal waveform built from the queued bytes.
module tb_io_uart_tx;

  localparam logic [9:0] A_TXDATA = 10'h000;
  localparam logic [9:0] A_BAUD   = 10'h001;
  localparam logic [9:0] A_CTRL   = 10'h002;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:2] st_adr_io;
  logic [31:0] st_data_io;
  logic [3:0]  st_we_io;
  logic        uart_tx, tx_busy, tx_overflow;
  logic [4:0]  fifo_level;

  int n_tests = 0;
  int n_fail  = 0;

  logic rec_en = 1'b0;
  bit   trace[$];
  bit   exp_q[$];

  always #5 clk = ~clk;

  io_uart_tx dut (
    .clk         (clk),
    .rst         (rst),
    .st_adr_io   (st_adr_io),
    .st_data_io  (st_data_io),
    .st_we_io    (st_we_io),
    .uart_tx     (uart_tx),
    .tx_busy     (tx_busy),
    .tx_overflow (tx_overflow),
    .fifo_level  (fifo_level)
  );

  // Line sampler, one sample per clock just after the active edge
  always @(posedge clk) begin
    #1;
    if (rec_en) trace.push_back(uart_tx);
  end

  task automatic chk(input string tag, input longint got, input longint want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  // One IO store sampled at the next rising edge; returns 1 time unit after that edge
  task automatic io_store(input logic [9:0] adr, input logic [31:0] data, input logic [3:0] we);
    @(negedge clk);
    st_adr_io  = adr;
    st_data_io = data;
    st_we_io   = we;
    @(posedge clk);
    #1;
    st_we_io = 4'h0;
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(1'b1);
  endtask

  // Ideal 8N1 frame: start 0, data LSB first, stop 1, each level for div cycles
  task automatic add_frame(input logic [7:0] b, input int div);
    bit lvl;
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      lvl = 1'b0;
      else if (k == 9) lvl = 1'b1;
      else             lvl = bit'((b >> (k - 1)) & 8'd1);
      for (int c = 0; c < div; c++) exp_q.push_back(lvl);
    end
  endtask

  // Next io_store lands on the second sample edge, so the line is idle for two samples
  task automatic start_rec();
    @(negedge clk);
    trace.delete();
    exp_q.delete();
    rec_en = 1'b1;
    add_idle(2);
  endtask

  task automatic finish_rec(input string tag);
    int guard = 0;
    int nmis  = 0;
    int first = -1;
    while (trace.size() < exp_q.size() && guard < 20000) begin
      @(posedge clk);
      guard++;
    end
    #2;
    rec_en = 1'b0;
    chk({tag, "_len_ok"}, longint'(trace.size() >= exp_q.size()), 1);
    for (int i = 0; i < exp_q.size() && i < trace.size(); i++) begin
      if (trace[i] != exp_q[i]) begin
        nmis++;
        if (first < 0) first = i;
      end
    end
    chk({tag, "_first_bad_sample"}, first, -1);
    chk({tag, "_bad_samples"}, nmis, 0);
  endtask

  initial begin
    logic [7:0] b0, b1, b2;
    logic [7:0] bytes[$];
    logic [9:0] jadr;
    logic [3:0] jwe;
    int         v, div, nb, gaps, kind;

    rst        = 1'b1;
    st_adr_io  = '0;
    st_data_io = '0;
    st_we_io   = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_uart_tx", uart_tx, 1);
    chk("reset_busy", tx_busy, 0);
    chk("reset_overflow", tx_overflow, 0);
    chk("reset_level", fifo_level, 0);

    // Single byte at divider 4
    io_store(A_BAUD, 32'd4, 4'b0011);
    start_rec();
    io_store(A_TXDATA, 32'h55, 4'b0001);
    add_frame(8'h55, 4);
    add_idle(4);
    chk("single_level_after_store", fifo_level, 1);
    chk("single_busy_after_store", tx_busy, 1);
    chk("single_line_high_after_store", uart_tx, 1);
    @(posedge clk); #1;
    chk("single_line_low_after_pop", uart_tx, 0);
    chk("single_level_after_pop", fifo_level, 0);
    finish_rec("single");
    chk("single_busy_done", tx_busy, 0);

    // Burst of 17 into an idle FSM fills the FIFO; the 18th overflows
    io_store(A_BAUD, 32'd2, 4'b0011);
    start_rec();
    for (int i = 0; i < 17; i++) begin
      b0 = 8'($urandom);
      io_store(A_TXDATA, {24'($urandom), b0}, 4'b0001);
      add_frame(b0, 2);
    end
    add_idle(4);
    chk("burst_level_full", fifo_level, 16);
    chk("burst_busy", tx_busy, 1);
    chk("burst_no_overflow_yet", tx_overflow, 0);
    io_store(A_TXDATA, 32'hEE, 4'b0001);
    chk("burst_overflow_set", tx_overflow, 1);
    chk("burst_level_still_full", fifo_level, 16);
    io_store(A_CTRL, 32'h1, 4'b0001);
    chk("burst_overflow_cleared", tx_overflow, 0);
    finish_rec("burst");
    chk("burst_level_drained", fifo_level, 0);

    // Clamp to 2, then a mid-frame baud change applies only to the next frame
    io_store(A_BAUD, 32'd0, 4'b0011);
    start_rec();
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    io_store(A_TXDATA, {24'h0, b0}, 4'b0001);
    io_store(A_TXDATA, {24'h0, b1}, 4'b0001);
    io_store(A_BAUD, 32'd8, 4'b0011);
    add_frame(b0, 2);
    add_frame(b1, 8);
    add_idle(4);
    finish_rec("baud_defer");

    // Byte-enable and address filtering
    io_store(A_TXDATA, 32'hA5, 4'b0010);
    chk("be_upper_level", fifo_level, 0);
    chk("be_upper_busy", tx_busy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("be_upper_line_idle", uart_tx, 1);
    io_store(10'h3FF, 32'h5A, 4'hF);
    chk("unmapped_level", fifo_level, 0);
    chk("unmapped_busy", tx_busy, 0);
    io_store(A_BAUD, 32'd3, 4'b0001);
    io_store(A_BAUD, 32'd3, 4'b1110);
    start_rec();
    b0 = 8'($urandom);
    io_store(A_TXDATA, {24'h0, b0}, 4'b1111);
    add_frame(b0, 8);
    add_idle(3);
    finish_rec("partial_baud_ignored");

    // Reset during data bit 3 discards everything and restores the default divider
    io_store(A_BAUD, 32'd4, 4'b0011);
    b0 = 8'($urandom);
    io_store(A_TXDATA, {24'h0, b0}, 4'b0001);
    io_store(A_TXDATA, 32'h11, 4'b0001);
    io_store(A_TXDATA, 32'h22, 4'b0001);
    repeat (16) @(posedge clk);
    @(negedge clk);
    chk("rst_pre_bit3", uart_tx, longint'((b0 >> 3) & 8'd1));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_line_high", uart_tx, 1);
    chk("rst_level", fifo_level, 0);
    chk("rst_busy", tx_busy, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("rst_no_resume_line", uart_tx, 1);
    chk("rst_no_resume_busy", tx_busy, 0);
    start_rec();
    b1 = 8'($urandom);
    io_store(A_TXDATA, {24'h0, b1}, 4'b0001);
    add_frame(b1, 434);
    add_idle(3);
    finish_rec("rst_default_baud");

    // Flush mid-frame: first frame completes, the rest never go out
    io_store(A_BAUD, 32'd3, 4'b0011);
    start_rec();
    b0 = 8'($urandom);
    io_store(A_TXDATA, {24'h0, b0}, 4'b0001);
    io_store(A_TXDATA, 32'h33, 4'b0001);
    io_store(A_TXDATA, 32'h44, 4'b0001);
    chk("flush_level_before", fifo_level, 2);
    repeat (2) @(posedge clk);
    io_store(A_CTRL, 32'h2, 4'b0001);
    chk("flush_level_after", fifo_level, 0);
    add_frame(b0, 3);
    add_idle(20);
    finish_rec("flush");
    chk("flush_busy_done", tx_busy, 0);

    // Randomized traffic with interleaved stores that must have no effect
    for (int it = 0; it < 30; it++) begin
      v   = $urandom_range(0, 8);
      div = (v < 2) ? 2 : v;
      io_store(A_BAUD, {16'($urandom), 16'(v)}, {2'($urandom), 2'b11});
      nb = $urandom_range(1, 6);
      bytes.delete();
      for (int i = 0; i < nb; i++) bytes.push_back(8'($urandom));
      start_rec();
      for (int i = 0; i < nb; i++) begin
        io_store(A_TXDATA, {24'($urandom), bytes[i]}, {3'($urandom), 1'b1});
        add_frame(bytes[i], div);
        gaps = $urandom_range(0, 3);
        for (int g = 0; g < gaps; g++) begin
          kind = $urandom_range(0, 3);
          case (kind)
            0: begin
              jadr = 10'($urandom_range(3, 1023));
              io_store(jadr, $urandom, 4'($urandom_range(1, 15)));
            end
            1: begin
              jwe = {3'($urandom_range(1, 7)), 1'b0};
              io_store(A_TXDATA, $urandom, jwe);
            end
            2: begin
              jwe = {2'($urandom), 2'($urandom_range(0, 2))};
              if (jwe == 4'h0) jwe = 4'b0100;
              io_store(A_BAUD, $urandom, jwe);
            end
            default: io_store(A_CTRL, 32'h1, 4'b0001);
          endcase
        end
      end
      add_idle(3);
      finish_rec($sformatf("rand%0d", it));
      chk($sformatf("rand%0d_overflow", it), tx_overflow, 0);
      chk($sformatf("rand%0d_level", it), fifo_level, 0);
      chk($sformatf("rand%0d_busy", it), tx_busy, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
